// File: rtl/vga_sprite_compositor.sv
// rtl/vga_sprite_compositor.sv - three-stage tile/sprite pixel compositor with double-buffered sprite slots
// Sprite slots are written into a pending bank and committed to the active bank on the first valid pixel of a frame.
module vga_sprite_compositor #(
  parameter  int NUM_SPRITES = 4,
  parameter  int SPRITE_SIZE = 42,
  parameter  int BLOCK_WIDTH = 40,
  parameter  int COORD_W     = 10,
  parameter  int LOCAL_W     = 6,
  parameter  int MAP_ROW_W   = 4,
  parameter  int MAP_COL_W   = 5,
  localparam int IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pix_valid,
  input  logic                           frame_start,
  input  logic [COORD_W-1:0]             row,
  input  logic [COORD_W-1:0]             col,
  input  logic                           spr_we,
  input  logic [IDX_W-1:0]               spr_idx,
  input  logic                           spr_en,
  input  logic [COORD_W-1:0]             spr_x,
  input  logic [COORD_W-1:0]             spr_y,
  output logic [MAP_ROW_W-1:0]           map_row,
  output logic [MAP_COL_W-1:0]           map_col,
  input  logic [7:0]                     map_code,
  output logic [NUM_SPRITES*LOCAL_W-1:0] spr_lx,
  output logic [NUM_SPRITES*LOCAL_W-1:0] spr_ly,
  input  logic [NUM_SPRITES*12-1:0]      spr_rgb,
  input  logic [NUM_SPRITES-1:0]         spr_transparent,
  output logic                           out_valid,
  output logic [3:0]                     red,
  output logic [3:0]                     green,
  output logic [3:0]                     blue
);

  localparam logic [COORD_W:0]   SPAN = (COORD_W+1)'(SPRITE_SIZE - 1);
  localparam logic [COORD_W-1:0] BW   = COORD_W'(BLOCK_WIDTH);

  function automatic logic [11:0] tile_rgb(input logic [7:0] code);
    case (code)
      8'd1:    tile_rgb = 12'h09F;
      8'd2:    tile_rgb = 12'h843;
      8'd3:    tile_rgb = 12'h0F2;
      8'd4:    tile_rgb = 12'h09F;
      default: tile_rgb = 12'h000;
    endcase
  endfunction

  logic [NUM_SPRITES-1:0] pend_en_q, pend_en_d, act_en_q, act_en_d;
  logic [COORD_W-1:0]     pend_x_q [NUM_SPRITES];
  logic [COORD_W-1:0]     pend_x_d [NUM_SPRITES];
  logic [COORD_W-1:0]     pend_y_q [NUM_SPRITES];
  logic [COORD_W-1:0]     pend_y_d [NUM_SPRITES];
  logic [COORD_W-1:0]     act_x_q  [NUM_SPRITES];
  logic [COORD_W-1:0]     act_x_d  [NUM_SPRITES];
  logic [COORD_W-1:0]     act_y_q  [NUM_SPRITES];
  logic [COORD_W-1:0]     act_y_d  [NUM_SPRITES];

  logic [MAP_ROW_W-1:0]           map_row_q, map_row_d;
  logic [MAP_COL_W-1:0]           map_col_q, map_col_d;
  logic [NUM_SPRITES*LOCAL_W-1:0] lx_q, lx_d, ly_q, ly_d;
  logic [NUM_SPRITES-1:0]         s0_hit_q, s0_hit_d;
  logic                           s0_valid_q, s0_valid_d;

  logic [7:0]                s1_code_q, s1_code_d;
  logic [NUM_SPRITES*12-1:0] s1_rgb_q, s1_rgb_d;
  logic [NUM_SPRITES-1:0]    s1_tr_q, s1_tr_d;
  logic [NUM_SPRITES-1:0]    s1_hit_q, s1_hit_d;
  logic                      s1_valid_q, s1_valid_d;

  logic        out_valid_q, out_valid_d;
  logic [11:0] rgb_q, rgb_d;

  logic commit;

  // Bank update; the commit sees this cycle's write so the new position applies to the same pixel.
  always_comb begin
    pend_en_d = pend_en_q;
    pend_x_d  = pend_x_q;
    pend_y_d  = pend_y_q;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (spr_we && spr_idx == IDX_W'(i)) begin
        pend_en_d[i] = spr_en;
        pend_x_d[i]  = spr_x;
        pend_y_d[i]  = spr_y;
      end
    end
    commit   = pix_valid && frame_start;
    act_en_d = commit ? pend_en_d : act_en_q;
    act_x_d  = commit ? pend_x_d  : act_x_q;
    act_y_d  = commit ? pend_y_d  : act_y_q;
  end

  // Stage 0: widened compares keep x+SPRITE_SIZE-1 from wrapping past the right edge.
  always_comb begin
    map_row_d  = MAP_ROW_W'(row / BW);
    map_col_d  = MAP_COL_W'(col / BW);
    s0_valid_d = pix_valid;
    s0_hit_d   = '0;
    lx_d       = '0;
    ly_d       = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      s0_hit_d[i] = act_en_d[i]
                 && ({1'b0, col} >= {1'b0, act_x_d[i]})
                 && ({1'b0, col} <= {1'b0, act_x_d[i]} + SPAN)
                 && ({1'b0, row} >= {1'b0, act_y_d[i]})
                 && ({1'b0, row} <= {1'b0, act_y_d[i]} + SPAN);
      lx_d[i*LOCAL_W +: LOCAL_W] = LOCAL_W'(col - act_x_d[i]);
      ly_d[i*LOCAL_W +: LOCAL_W] = LOCAL_W'(row - act_y_d[i]);
    end
  end

  always_comb begin
    s1_code_d  = map_code;
    s1_rgb_d   = spr_rgb;
    s1_tr_d    = spr_transparent;
    s1_hit_d   = s0_hit_q;
    s1_valid_d = s0_valid_q;
  end

  // Stage 2: lowest-index opaque hit wins, otherwise the tile palette colour.
  always_comb begin
    logic found;
    found       = 1'b0;
    rgb_d       = tile_rgb(s1_code_q);
    out_valid_d = s1_valid_q;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (!found && s1_hit_q[i] && !s1_tr_q[i]) begin
        rgb_d = s1_rgb_q[i*12 +: 12];
        found = 1'b1;
      end
    end
    if (!s1_valid_q) rgb_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_en_q   <= '0;
      act_en_q    <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        pend_x_q[i] <= '0;
        pend_y_q[i] <= '0;
        act_x_q[i]  <= '0;
        act_y_q[i]  <= '0;
      end
      map_row_q   <= '0;
      map_col_q   <= '0;
      lx_q        <= '0;
      ly_q        <= '0;
      s0_hit_q    <= '0;
      s0_valid_q  <= 1'b0;
      s1_code_q   <= '0;
      s1_rgb_q    <= '0;
      s1_tr_q     <= '0;
      s1_hit_q    <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      pend_en_q   <= pend_en_d;
      act_en_q    <= act_en_d;
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      act_x_q     <= act_x_d;
      act_y_q     <= act_y_d;
      map_row_q   <= map_row_d;
      map_col_q   <= map_col_d;
      lx_q        <= lx_d;
      ly_q        <= ly_d;
      s0_hit_q    <= s0_hit_d;
      s0_valid_q  <= s0_valid_d;
      s1_code_q   <= s1_code_d;
      s1_rgb_q    <= s1_rgb_d;
      s1_tr_q     <= s1_tr_d;
      s1_hit_q    <= s1_hit_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      rgb_q       <= rgb_d;
    end
  end

  assign map_row   = map_row_q;
  assign map_col   = map_col_q;
  assign spr_lx    = lx_q;
  assign spr_ly    = ly_q;
  assign out_valid = out_valid_q;
  assign red       = rgb_q[11:8];
  assign green     = rgb_q[7:4];
  assign blue      = rgb_q[3:0];

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// tb/tb_vga_sprite_compositor.sv - scoreboard bench for vga_sprite_compositor
// Stimulus pushes expected pixels from a behavioural model; a monitor pops on out_valid.
module tb_vga_sprite_compositor;
  localparam int NS = 4;
  localparam int SZ = 42;
  localparam int BWD = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_valid, frame_start;
  logic [9:0]  row, col;
  logic        spr_we;
  logic [1:0]  spr_idx;
  logic        spr_en;
  logic [9:0]  spr_x, spr_y;
  logic [3:0]  map_row;
  logic [4:0]  map_col;
  logic [7:0]  map_code;
  logic [NS*6-1:0]  spr_lx, spr_ly;
  logic [NS*12-1:0] spr_rgb;
  logic [NS-1:0]    spr_transparent;
  logic        out_valid;
  logic [3:0]  red, green, blue;

  vga_sprite_compositor dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .frame_start(frame_start),
    .row(row), .col(col), .spr_we(spr_we), .spr_idx(spr_idx), .spr_en(spr_en),
    .spr_x(spr_x), .spr_y(spr_y), .map_row(map_row), .map_col(map_col),
    .map_code(map_code), .spr_lx(spr_lx), .spr_ly(spr_ly), .spr_rgb(spr_rgb),
    .spr_transparent(spr_transparent), .out_valid(out_valid),
    .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  // External tile map and sprite ROMs
  logic [7:0]  code_tbl [16][32];
  logic [11:0] rom_color [NS];
  int          tr_mode [NS];
  bit          rom_pat;

  assign map_code = code_tbl[map_row][map_col];

  always_comb begin
    logic [5:0] lx_t, ly_t;
    lx_t = '0;
    ly_t = '0;
    spr_rgb = '0;
    spr_transparent = '0;
    for (int i = 0; i < NS; i++) begin
      lx_t = spr_lx[i*6 +: 6];
      ly_t = spr_ly[i*6 +: 6];
      spr_rgb[i*12 +: 12] = rom_color[i] ^ (rom_pat ? {lx_t[3:0], ly_t[3:0], 4'h0} : 12'h000);
      spr_transparent[i] = (tr_mode[i] == 1) || (tr_mode[i] == 2 && (lx_t[0] ^ ly_t[0]));
    end
  end

  typedef struct { int due; logic [11:0] rgb; } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int p_en[NS], p_x[NS], p_y[NS];
  int a_en[NS], a_x[NS], a_y[NS];
  bit w_we = 0;
  int w_idx, w_en, w_x, w_y;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] palette(input int code);
    case (code)
      1: return 12'h09F;
      2: return 12'h843;
      3: return 12'h0F2;
      4: return 12'h09F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] model_pixel(input int r, input int c);
    int lx, ly;
    logic [11:0] col_v;
    for (int i = 0; i < NS; i++) begin
      if (a_en[i] != 0 && c >= a_x[i] && c < a_x[i] + SZ && r >= a_y[i] && r < a_y[i] + SZ) begin
        lx = c - a_x[i];
        ly = r - a_y[i];
        if (!(tr_mode[i] == 1 || (tr_mode[i] == 2 && ((lx % 2) != (ly % 2))))) begin
          col_v = rom_color[i];
          if (rom_pat) col_v = col_v ^ 12'(((lx % 16) << 8) | ((ly % 16) << 4));
          return col_v;
        end
      end
    end
    return palette(int'(code_tbl[r / BWD][c / BWD]));
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel: got out_valid=1 rgb=%03h expected no output (cycle %0d)",
                 {red, green, blue}, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("pixel_rgb", 32'({red, green, blue}), 32'(e.rgb));
        chk("pixel_latency", 32'(cyc), 32'(e.due));
      end
    end else begin
      chk("idle_rgb_zero", 32'({red, green, blue}), 32'h0);
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_pixel: got out_valid=0 expected rgb=%03h due cycle %0d (cycle %0d)",
                 e.rgb, e.due, cyc);
      end
    end
  end

  task automatic issue(input bit v, input bit fs, input int r, input int c);
    exp_t e;
    reset       = 1'b0;
    pix_valid   = v;
    frame_start = fs;
    row         = 10'(r);
    col         = 10'(c);
    spr_we      = w_we;
    spr_idx     = 2'(w_idx);
    spr_en      = (w_en != 0);
    spr_x       = 10'(w_x);
    spr_y       = 10'(w_y);
    if (w_we) begin
      p_en[w_idx] = w_en;
      p_x[w_idx]  = w_x;
      p_y[w_idx]  = w_y;
    end
    if (v && fs) begin
      for (int i = 0; i < NS; i++) begin
        a_en[i] = p_en[i]; a_x[i] = p_x[i]; a_y[i] = p_y[i];
      end
    end
    if (v) begin
      e.due = cyc + 3;
      e.rgb = model_pixel(r, c);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    w_we = 1'b0;
  endtask

  task automatic set_write(input int idx, input int en, input int x, input int y);
    w_we = 1'b1; w_idx = idx; w_en = en; w_x = x; w_y = y;
  endtask

  task automatic span(input int r, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) issue(1'b1, 1'b0, r, c);
  endtask

  task automatic drain();
    repeat (5) issue(1'b0, 1'b0, 0, 0);
  endtask

  task automatic fill_map(input int code);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 32; c++)
        code_tbl[r][c] = 8'(code);
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_rgb", 32'({red, green, blue}), 32'h0);
    chk("rst_map_row", 32'(map_row), 32'h0);
    chk("rst_map_col", 32'(map_col), 32'h0);
    chk("rst_spr_lx", 32'(spr_lx), 32'h0);
    chk("rst_spr_ly", 32'(spr_ly), 32'h0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; pix_valid = 1'b0; frame_start = 1'b0; spr_we = 1'b0;
    while (exp_q.size() > 0 && exp_q[$].due > cyc) exp_q.pop_back();
    for (int i = 0; i < NS; i++) begin
      p_en[i] = 0; p_x[i] = 0; p_y[i] = 0;
      a_en[i] = 0; a_x[i] = 0; a_y[i] = 0;
    end
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    check_reset_state();
  endtask

  task automatic rand_write();
    int x, y;
    x = ($urandom % 8 == 0) ? int'($urandom_range(600, 1023)) : int'($urandom_range(0, 639));
    y = ($urandom % 8 == 0) ? int'($urandom_range(440, 1023)) : int'($urandom_range(0, 479));
    set_write(int'($urandom % NS), ($urandom % 4 != 0) ? 1 : 0, x, y);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1);
  end

  initial begin
    int r, c0, len, s;
    reset = 1'b1; pix_valid = 0; frame_start = 0; row = 0; col = 0;
    spr_we = 0; spr_idx = 0; spr_en = 0; spr_x = 0; spr_y = 0;
    rom_pat = 0;
    for (int i = 0; i < NS; i++) begin
      rom_color[i] = 12'h000; tr_mode[i] = 0;
      p_en[i] = 0; p_x[i] = 0; p_y[i] = 0; a_en[i] = 0; a_x[i] = 0; a_y[i] = 0;
    end
    fill_map(3);
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();

    // Ground-only frame
    issue(1'b1, 1'b1, 0, 0);
    span(0, 1, 30);
    span(100, 600, 639);
    drain();

    // Mid-frame write takes effect only at the next frame
    rom_color[0] = 12'hF00;
    span(210, 95, 110);
    set_write(0, 1, 100, 200);
    issue(1'b1, 1'b0, 210, 111);
    span(210, 112, 145);
    issue(1'b1, 1'b1, 0, 0);
    span(199, 95, 145);
    span(200, 95, 145);
    span(241, 95, 145);
    span(242, 95, 145);
    drain();

    // Priority and transparency with overlapping slots
    fill_map(2);
    rom_color[0] = 12'h00F;
    rom_color[1] = 12'h0F0;
    set_write(0, 1, 300, 300);
    issue(1'b0, 1'b0, 0, 0);
    set_write(1, 1, 300, 300);
    issue(1'b0, 1'b0, 0, 0);
    issue(1'b1, 1'b1, 0, 0);
    span(310, 295, 345);
    drain();
    tr_mode[0] = 1;
    issue(1'b1, 1'b1, 0, 0);
    span(320, 298, 343);
    drain();
    tr_mode[1] = 1;
    issue(1'b1, 1'b1, 0, 0);
    span(330, 298, 343);
    drain();
    tr_mode[0] = 0;
    tr_mode[1] = 0;

    // Right-edge clipping without wraparound
    fill_map(1);
    rom_color[2] = 12'h5A5;
    rom_color[1] = 12'hC3C;
    set_write(2, 1, 630, 10);
    issue(1'b0, 1'b0, 0, 0);
    set_write(1, 1, 1000, 20);
    issue(1'b0, 1'b0, 0, 0);
    set_write(0, 0, 0, 0);
    issue(1'b1, 1'b1, 0, 0);
    span(20, 0, 40);
    span(20, 620, 639);
    drain();

    // Write on the frame_start cycle is used for pixel (0,0)
    rom_color[3] = 12'hABC;
    set_write(3, 1, 0, 0);
    issue(1'b1, 1'b1, 0, 0);
    span(0, 1, 50);
    drain();

    // Reset mid-line
    set_write(2, 1, 10, 90);
    issue(1'b1, 1'b1, 0, 0);
    span(100, 0, 30);
    do_reset(1);
    span(100, 31, 60);
    issue(1'b1, 1'b1, 0, 0);
    span(100, 0, 60);
    drain();

    // Randomised frames
    for (int f = 0; f < 8; f++) begin
      for (int rr = 0; rr < 16; rr++)
        for (int cc = 0; cc < 32; cc++)
          code_tbl[rr][cc] = 8'($urandom_range(0, 7));
      for (int i = 0; i < NS; i++) begin
        rom_color[i] = 12'($urandom);
        tr_mode[i] = int'($urandom_range(0, 2));
      end
      rom_pat = 1'($urandom);
      if ($urandom % 2 == 0) rand_write();
      issue(1'b1, 1'b1, 0, 0);
      for (int k = 0; k < 8; k++) begin
        repeat ($urandom_range(0, 3)) begin
          if ($urandom % 3 == 0) rand_write();
          issue(1'b0, ($urandom % 4) == 0, 0, 0);
        end
        s = int'($urandom % NS);
        r = p_y[s] + int'($urandom_range(0, 45)) - 2;
        if (r < 0) r = 0;
        if (r > 479) r = int'($urandom_range(0, 479));
        c0 = p_x[s] - 3;
        if (c0 < 0) c0 = 0;
        if (c0 > 600) c0 = int'($urandom_range(0, 600));
        len = int'($urandom_range(20, 39));
        for (int j = 0; j < len; j++) begin
          if ($urandom % 10 == 0) rand_write();
          issue(1'b1, ($urandom % 40) == 0, r, c0 + j);
        end
      end
      drain();
    end

    drain();
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
